// File: rtl/d_ff_pipe_pkg.sv
// Shared sizing helpers for the d_ff_pipe delay line.
// Both tap-select and occupancy widths are clog2 clamped to a minimum of one bit.
package d_ff_pipe_pkg;

  function automatic int unsigned clog2_min1(input int unsigned n);
    int unsigned r;
    r = 32'($clog2(n));
    return (r < 32'd1) ? 32'd1 : r;
  endfunction

  // Bits needed to address any stage of a DEPTH-deep line.
  function automatic int unsigned tap_width(input int unsigned depth);
    return clog2_min1(depth);
  endfunction

  // Bits needed to count 0..DEPTH valid stages.
  function automatic int unsigned occ_width(input int unsigned depth);
    return clog2_min1(depth + 32'd1);
  endfunction

endpackage

// File: rtl/d_ff_stage.sv
// One stage of the delay line: WIDTH data bits plus a valid bit.
// Priority reset > clear_valid > load; clear_valid leaves the data untouched.
module d_ff_stage #(
  parameter int unsigned      WIDTH       = 8,
  parameter logic [WIDTH-1:0] RESET_VALUE = '0
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             load,
  input  logic             clear_valid,
  input  logic [WIDTH-1:0] d,
  input  logic             d_valid,
  output logic [WIDTH-1:0] q,
  output logic             q_valid
);

  always_ff @(posedge clock) begin
    if (reset) begin
      q       <= RESET_VALUE;
      q_valid <= 1'b0;
    end else if (clear_valid) begin
      q_valid <= 1'b0;
    end else if (load) begin
      q       <= d;
      q_valid <= d_valid;
    end
  end

endmodule

// File: rtl/d_ff_pipe.sv
// Enable-gated, flushable delay line of DEPTH stages with a registered
// occupancy counter and a combinational tap onto any stage.
module d_ff_pipe
  import d_ff_pipe_pkg::*;
#(
  parameter int unsigned      WIDTH       = 8,
  parameter int unsigned      DEPTH       = 4,
  parameter logic [WIDTH-1:0] RESET_VALUE = '0,
  localparam int unsigned     TW          = tap_width(DEPTH),
  localparam int unsigned     OW          = occ_width(DEPTH)
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             enable,
  input  logic             flush,
  input  logic [WIDTH-1:0] data,
  input  logic             data_valid,
  input  logic [TW-1:0]    tap_sel,
  output logic [WIDTH-1:0] out,
  output logic             out_valid,
  output logic [WIDTH-1:0] tap_out,
  output logic             tap_valid,
  output logic [OW-1:0]    occupancy
);

  logic [WIDTH-1:0] stage_data [DEPTH];
  logic [DEPTH-1:0] stage_valid;

  // Stage 0 takes the input port, every later stage takes its predecessor.
  for (genvar i = 0; i < DEPTH; i++) begin : g_stage
    logic [WIDTH-1:0] d_in;
    logic             v_in;

    if (i == 0) begin : g_head
      assign d_in = data;
      assign v_in = data_valid;
    end else begin : g_body
      assign d_in = stage_data[i-1];
      assign v_in = stage_valid[i-1];
    end

    d_ff_stage #(
      .WIDTH       (WIDTH),
      .RESET_VALUE (RESET_VALUE)
    ) u_stage (
      .clock       (clock),
      .reset       (reset),
      .load        (enable),
      .clear_valid (flush),
      .d           (d_in),
      .d_valid     (v_in),
      .q           (stage_data[i]),
      .q_valid     (stage_valid[i])
    );
  end

  assign out       = stage_data[DEPTH-1];
  assign out_valid = stage_valid[DEPTH-1];

  // Entering valid adds one, leaving valid removes one; both can cancel out.
  always_ff @(posedge clock) begin
    if (reset || flush) begin
      occupancy <= '0;
    end else if (enable) begin
      occupancy <= occupancy + OW'(data_valid) - OW'(stage_valid[DEPTH-1]);
    end
  end

  // Out-of-range selects read back as an empty reset stage.
  always_comb begin
    tap_out   = RESET_VALUE;
    tap_valid = 1'b0;
    for (int unsigned i = 0; i < DEPTH; i++) begin
      if (tap_sel == TW'(i)) begin
        tap_out   = stage_data[i];
        tap_valid = stage_valid[i];
      end
    end
  end

endmodule

// File: tb/tb_d_ff_pipe.sv
// Self-checking bench for d_ff_pipe: a DEPTH=4 and a DEPTH=3 instance share stimulus
// and are compared against queue-based reference models.
module tb_d_ff_pipe;

  localparam logic [7:0] RV = 8'h00;

  logic       clock = 1'b0;
  logic       reset, enable, flush, data_valid;
  logic [7:0] data;
  logic [1:0] tap_sel;

  logic [7:0] out4, tap4, out3, tap3;
  logic       ov4, tv4, ov3, tv3;
  logic [2:0] occ4;
  logic [1:0] occ3;

  int tests = 0;
  int fails = 0;

  // Reference: front of queue is the input end, back is the output end.
  logic [7:0] q4d[$];
  logic       q4v[$];
  logic [7:0] q3d[$];
  logic       q3v[$];

  always #5 clock = ~clock;

  d_ff_pipe #(.WIDTH(8), .DEPTH(4), .RESET_VALUE(RV)) u_dut4 (
    .clock(clock), .reset(reset), .enable(enable), .flush(flush),
    .data(data), .data_valid(data_valid), .tap_sel(tap_sel),
    .out(out4), .out_valid(ov4), .tap_out(tap4), .tap_valid(tv4), .occupancy(occ4)
  );

  d_ff_pipe #(.WIDTH(8), .DEPTH(3), .RESET_VALUE(RV)) u_dut3 (
    .clock(clock), .reset(reset), .enable(enable), .flush(flush),
    .data(data), .data_valid(data_valid), .tap_sel(tap_sel),
    .out(out3), .out_valid(ov3), .tap_out(tap3), .tap_valid(tv3), .occupancy(occ3)
  );

  function automatic int m_occ4();
    int n = 0;
    foreach (q4v[i]) n += int'(q4v[i]);
    return n;
  endfunction

  function automatic int m_occ3();
    int n = 0;
    foreach (q3v[i]) n += int'(q3v[i]);
    return n;
  endfunction

  function automatic logic [8:0] m_tap4(input int sel);
    return (sel < 4) ? {q4v[sel], q4d[sel]} : {1'b0, RV};
  endfunction

  function automatic logic [8:0] m_tap3(input int sel);
    return (sel < 3) ? {q3v[sel], q3d[sel]} : {1'b0, RV};
  endfunction

  // Drive one edge's inputs, clock it, and advance the reference model.
  task automatic tick(input logic rs, input logic fl, input logic en,
                      input logic [7:0] d, input logic dv);
    reset = rs; flush = fl; enable = en; data = d; data_valid = dv;
    @(posedge clock);
    #1;
    if (rs) begin
      foreach (q4d[i]) begin q4d[i] = RV; q4v[i] = 1'b0; end
      foreach (q3d[i]) begin q3d[i] = RV; q3v[i] = 1'b0; end
    end else if (fl) begin
      foreach (q4v[i]) q4v[i] = 1'b0;
      foreach (q3v[i]) q3v[i] = 1'b0;
    end else if (en) begin
      q4d.push_front(d); q4v.push_front(dv);
      void'(q4d.pop_back()); void'(q4v.pop_back());
      q3d.push_front(d); q3v.push_front(dv);
      void'(q3d.pop_back()); void'(q3v.pop_back());
    end
  endtask

  task automatic test_reset();
    tick(1'b1, 1'b0, 1'b1, 8'hFF, 1'b1);
    tick(1'b1, 1'b0, 1'b1, 8'hFF, 1'b1);
    reset = 1'b0; enable = 1'b0;
    tests++;
    if ({out4, ov4, occ4} !== {8'h00, 1'b0, 3'd0}) begin
      fails++;
      $display("FAIL reset_out4: got out=%h v=%b occ=%0d, expected out=00 v=0 occ=0", out4, ov4, occ4);
    end
    tests++;
    if ({out3, ov3, occ3} !== {8'h00, 1'b0, 2'd0}) begin
      fails++;
      $display("FAIL reset_out3: got out=%h v=%b occ=%0d, expected out=00 v=0 occ=0", out3, ov3, occ3);
    end
    for (int s = 0; s < 4; s++) begin
      tap_sel = 2'(s);
      #1;
      tests++;
      if ({tv4, tap4, tv3, tap3} !== {1'b0, RV, 1'b0, RV}) begin
        fails++;
        $display("FAIL reset_tap sel=%0d: got d4=%b/%h d3=%b/%h, expected invalid/%h", s, tv4, tap4, tv3, tap3, RV);
      end
    end
  endtask

  task automatic test_stream();
    logic [7:0] words [5] = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h55};
    logic [2:0] occ_exp [5] = '{3'd1, 3'd2, 3'd3, 3'd4, 3'd4};
    tick(1'b1, 1'b0, 1'b0, 8'h00, 1'b0);
    for (int e = 0; e < 5; e++) begin
      tick(1'b0, 1'b0, 1'b1, words[e], 1'b1);
      tests++;
      if (occ4 !== occ_exp[e]) begin
        fails++;
        $display("FAIL stream_occ edge%0d: got %0d, expected %0d", e + 1, occ4, occ_exp[e]);
      end
      tests++;
      if ({ov4, out4} !== {q4v[3], q4d[3]} || (e == 3 && {ov4, out4} !== {1'b1, 8'h11})
          || (e == 4 && {ov4, out4} !== {1'b1, 8'h22})) begin
        fails++;
        $display("FAIL stream_out edge%0d: got v=%b out=%h, expected v=%b out=%h", e + 1, ov4, out4, q4v[3], q4d[3]);
      end
      tests++;
      if ({ov3, out3, occ3} !== {q3v[2], q3d[2], 2'(m_occ3())}) begin
        fails++;
        $display("FAIL stream_d3 edge%0d: got v=%b out=%h occ=%0d, expected v=%b out=%h occ=%0d",
                 e + 1, ov3, out3, occ3, q3v[2], q3d[2], m_occ3());
      end
    end
  endtask

  task automatic test_stall();
    logic [7:0] got[$];
    logic [7:0] expq[$] = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h55, 8'h66, 8'h77};
    logic [7:0] feed [11] = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h55, 8'h66, 8'h77, 8'h00, 8'h00, 8'h00, 8'h00};
    tick(1'b1, 1'b0, 1'b0, 8'h00, 1'b0);
    for (int e = 0; e < 11; e++) begin
      if (e == 5) begin
        for (int s = 0; s < 3; s++) begin
          tick(1'b0, 1'b0, 1'b0, 8'($urandom), 1'b1);
          tests++;
          if ({ov4, out4, occ4} !== {1'b1, 8'h22, 3'd4}) begin
            fails++;
            $display("FAIL stall_frozen cycle%0d: got v=%b out=%h occ=%0d, expected v=1 out=22 occ=4", s, ov4, out4, occ4);
          end
        end
      end
      tick(1'b0, 1'b0, 1'b1, feed[e], e < 7);
      if (ov4) got.push_back(out4);
    end
    tests++;
    if (got != expq) begin
      fails++;
      $display("FAIL stall_sequence: got %p, expected %p", got, expq);
    end
  endtask

  task automatic test_bubbles();
    logic [7:0] w [3] = '{8'hA0, 8'hA1, 8'hA2};
    logic       v [3] = '{1'b1, 1'b0, 1'b1};
    tick(1'b1, 1'b0, 1'b0, 8'h00, 1'b0);
    for (int e = 0; e < 6; e++) begin
      tick(1'b0, 1'b0, 1'b1, (e < 3) ? w[e] : 8'h00, (e < 3) ? v[e] : 1'b0);
      if (e < 3) begin
        tests++;
        if (occ4 > 3'd2 || int'(occ4) != m_occ4()) begin
          fails++;
          $display("FAIL bubble_occ edge%0d: got %0d, expected %0d (<=2)", e + 1, occ4, m_occ4());
        end
      end else begin
        tests++;
        if ({ov4, out4} !== {v[e-3], w[e-3]}) begin
          fails++;
          $display("FAIL bubble_out edge%0d: got v=%b out=%h, expected v=%b out=%h", e + 1, ov4, out4, v[e-3], w[e-3]);
        end
      end
    end
  endtask

  task automatic test_flush();
    tick(1'b1, 1'b0, 1'b0, 8'h00, 1'b0);
    tick(1'b0, 1'b0, 1'b1, 8'h31, 1'b1);
    tick(1'b0, 1'b0, 1'b1, 8'h32, 1'b1);
    tick(1'b0, 1'b0, 1'b1, 8'h33, 1'b1);
    tests++;
    if (occ4 !== 3'd3) begin
      fails++;
      $display("FAIL flush_pre_occ: got %0d, expected 3", occ4);
    end
    tick(1'b0, 1'b1, 1'b1, 8'h77, 1'b1);
    tests++;
    if ({occ4, ov4, occ3, ov3} !== {3'd0, 1'b0, 2'd0, 1'b0}) begin
      fails++;
      $display("FAIL flush_clear: got occ4=%0d v4=%b occ3=%0d v3=%b, expected all 0", occ4, ov4, occ3, ov3);
    end
    tap_sel = 2'd0;
    #1;
    tests++;
    if ({tv4, tap4} !== {1'b0, 8'h33}) begin
      fails++;
      $display("FAIL flush_tap0: got v=%b d=%h, expected v=0 d=33", tv4, tap4);
    end
    tap_sel = 2'd2;
    #1;
    tests++;
    if ({tv4, tap4, tv3, tap3} !== {1'b0, 8'h31, 1'b0, 8'h31}) begin
      fails++;
      $display("FAIL flush_tap2: got d4=%b/%h d3=%b/%h, expected 0/31 0/31", tv4, tap4, tv3, tap3);
    end
    tick(1'b0, 1'b0, 1'b0, 8'h55, 1'b1);
    tests++;
    if (occ4 !== 3'd0) begin
      fails++;
      $display("FAIL flush_hold_occ: got %0d, expected 0", occ4);
    end
  endtask

  task automatic test_tap();
    logic [7:0] exp4 [4] = '{8'h44, 8'h33, 8'h22, 8'h11};
    tick(1'b1, 1'b0, 1'b0, 8'h00, 1'b0);
    tick(1'b0, 1'b0, 1'b1, 8'h11, 1'b1);
    tick(1'b0, 1'b0, 1'b1, 8'h22, 1'b1);
    tick(1'b0, 1'b0, 1'b1, 8'h33, 1'b1);
    tick(1'b0, 1'b0, 1'b1, 8'h44, 1'b1);
    enable = 1'b0;
    for (int s = 0; s < 4; s++) begin
      tap_sel = 2'(s);
      #1;
      tests++;
      if ({tv4, tap4} !== {1'b1, exp4[s]}) begin
        fails++;
        $display("FAIL tap4 sel=%0d: got v=%b d=%h, expected v=1 d=%h", s, tv4, tap4, exp4[s]);
      end
      tests++;
      if ({tv3, tap3} !== m_tap3(s) || (s == 3 && {tv3, tap3} !== {1'b0, RV})) begin
        fails++;
        $display("FAIL tap3 sel=%0d: got v=%b d=%h, expected %h", s, tv3, tap3, m_tap3(s));
      end
    end
  endtask

  task automatic test_random();
    int errs = 0;
    tick(1'b1, 1'b0, 1'b0, 8'h00, 1'b0);
    for (int c = 0; c < 600; c++) begin
      tap_sel = 2'($urandom_range(0, 3));
      tick($urandom_range(0, 99) < 2, $urandom_range(0, 99) < 5, $urandom_range(0, 9) < 7,
           8'($urandom), 1'($urandom));
      tests++;
      if ({ov4, out4, occ4} !== {q4v[3], q4d[3], 3'(m_occ4())} ||
          {ov3, out3, occ3} !== {q3v[2], q3d[2], 2'(m_occ3())}) begin
        fails++;
        if (errs++ < 10)
          $display("FAIL random_out cycle%0d: got d4=%b/%h/%0d d3=%b/%h/%0d, expected d4=%b/%h/%0d d3=%b/%h/%0d",
                   c, ov4, out4, occ4, ov3, out3, occ3, q4v[3], q4d[3], m_occ4(), q3v[2], q3d[2], m_occ3());
      end
      tests++;
      if ({tv4, tap4} !== m_tap4(int'(tap_sel)) || {tv3, tap3} !== m_tap3(int'(tap_sel))) begin
        fails++;
        if (errs++ < 10)
          $display("FAIL random_tap cycle%0d sel=%0d: got d4=%b/%h d3=%b/%h, expected d4=%h d3=%h",
                   c, tap_sel, tv4, tap4, tv3, tap3, m_tap4(int'(tap_sel)), m_tap3(int'(tap_sel)));
      end
    end
  endtask

  initial begin
    reset = 1'b1; enable = 1'b0; flush = 1'b0; data = 8'h00; data_valid = 1'b0; tap_sel = 2'd0;
    for (int i = 0; i < 4; i++) begin q4d.push_back(RV); q4v.push_back(1'b0); end
    for (int i = 0; i < 3; i++) begin q3d.push_back(RV); q3v.push_back(1'b0); end
    test_reset();
    test_stream();
    test_stall();
    test_bubbles();
    test_flush();
    test_tap();
    test_random();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/d_ff_pipe.md
# d_ff_pipe

Parametrised, enable-gated delay line: a chain of DEPTH registers, each WIDTH bits wide and each carrying a valid bit. It generalises the single-bit D flip-flop to multi-bit data with configurable latency, stall, flush, an occupancy count and a selectable tap. It sits between producer and consumer logic to retime and delay data by a fixed, programmable number of enabled clock edges.

## Interface
- WIDTH, 8, data width in bits (≥1)
- DEPTH, 4, number of stages, i.e. latency in enabled cycles (≥1)
- RESET_VALUE, 0, WIDTH-bit value loaded into every stage on reset
- clock  input  1  rising-edge clock, single clock domain
- reset  input  1  synchronous, active-high reset
- enable  input  1  advance the line by one stage this edge
- flush  input  1  invalidate all stages this edge
- data  input  WIDTH  data entering stage 0
- data_valid  input  1  qualifies data
- tap_sel  input  TW  stage index to observe; TW = max(1, clog2(DEPTH))
- out  output  WIDTH  contents of stage DEPTH-1
- out_valid  output  1  valid bit of stage DEPTH-1
- tap_out  output  WIDTH  contents of stage tap_sel
- tap_valid  output  1  valid bit of stage tap_sel
- occupancy  output  OW  count of valid stages; OW = clog2(DEPTH+1)

## Operation
- Each stage i holds stage_data[i] and stage_valid[i]. Stage 0 is the input end, stage DEPTH-1 drives out/out_valid directly (no extra register).
- Edge priority: reset > flush > enable > hold.
- reset: all stage_data = RESET_VALUE, all stage_valid = 0, occupancy = 0.
- flush (reset low): all stage_valid = 0, occupancy = 0; stage_data unchanged; enable and data ignored that edge.
- enable (reset, flush low): stage_data[0] <= data, stage_valid[0] <= data_valid; stage[i] <= stage[i-1] for i ≥ 1; the entry in stage DEPTH-1 is discarded.
- enable low: all stages hold; data/data_valid are ignored.
- data is captured regardless of data_valid; invalid entries still move through the line with their data.
- occupancy is a registered counter, not a combinational popcount. On an enabled edge: occupancy <= occupancy + data_valid − stage_valid[DEPTH-1]. Both terms may be 1 on the same edge, giving a net change of 0. The counter never exceeds DEPTH and never underflows. The verifier checks occupancy == popcount(stage_valid) every cycle.
- tap_out/tap_valid: combinational mux of stage[tap_sel]. If tap_sel ≥ DEPTH: tap_out = RESET_VALUE, tap_valid = 0.
- DEPTH = 1: a single register; tap_sel is 1 bit and value 1 is out of range.

## Timing
- Reset values: out = RESET_VALUE, out_valid = 0, occupancy = 0, tap_out = RESET_VALUE, tap_valid = 0.
- Latency: data presented at enabled edge n appears on out after enabled edge n+DEPTH-1, i.e. DEPTH enabled edges in total. Cycles with enable low add no latency count.
- All outputs change only on the rising clock edge, except tap_out/tap_valid, which also follow tap_sel combinationally.
- Reset or flush asserted mid-stream takes effect on that edge. Entries in flight are lost or invalidated; there is no partial drain.
- flush and enable asserted together: the flush wins, and the incoming data_valid is dropped.

## Structure
- Shared package holds the width helper functions used for TW and OW (clog2 with a minimum of 1). The top uses it to size tap_sel and occupancy.
- One natural sub-module: d_ff_stage, a WIDTH+1-bit register with synchronous reset to RESET_VALUE/0, a clear-valid input and a load enable. It is instantiated DEPTH times in a generate loop.
- The occupancy counter and tap mux live in the top module.

## Test plan
- Reset: hold reset for 2 cycles with data = 8'hFF, data_valid = 1 -> out = 8'h00, out_valid = 0, occupancy = 0, all taps invalid.
- Streaming, DEPTH = 4: with enable high, drive 8'h11, 8'h22, 8'h33, 8'h44, 8'h55 valid on consecutive edges -> out = 8'h11, out_valid = 1 after the 4th edge, then 8'h22 after the 5th; occupancy reads 1, 2, 3, 4, 4.
- Stall: pulse enable low for 3 cycles mid-stream -> out and occupancy frozen for those cycles, then the sequence resumes with no loss or duplication.
- Bubbles: drive 8'hA0 valid, 8'hA1 invalid, 8'hA2 valid -> out_valid sequence 1, 0, 1 at the output; occupancy never exceeds 2 during fill.
- Flush: assert flush together with enable and data_valid = 1 while occupancy = 3 -> next cycle occupancy = 0, out_valid = 0, stage data unchanged, the incoming word is dropped.
- Tap: with the line filled with 8'h11..8'h44, sweep tap_sel from 0 to 3 -> tap_out = 8'h44, 8'h33, 8'h22, 8'h11 with tap_valid = 1. For DEPTH = 3 with tap_sel = 3 -> tap_out = RESET_VALUE, tap_valid = 0.
